// File: rtl/shift_unit.sv
// shift_unit: multi-cycle SLL/SRL/SRA/ROR shifter moving up to STEP bits per cycle.
module shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   din,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    // one extra bit so STEP == WIDTH == 2^SHAMT_W still fits
    localparam logic [SHAMT_W:0] STEP_X = (SHAMT_W+1)'(STEP);
    state_t             state;
    logic [WIDTH-1:0]   acc, acc_nx;
    logic [SHAMT_W-1:0] rem, rem_nx;
    logic [1:0]         op;
    logic [SHAMT_W:0]   n;
    logic [2*WIDTH-1:0] rot;
    always_comb begin
        n      = ({1'b0, rem} < STEP_X) ? {1'b0, rem} : STEP_X;
        rem_nx = rem - n[SHAMT_W-1:0];
        rot    = {acc, acc} >> n;
        acc_nx = (op == 2'b00) ? acc << n :
                 (op == 2'b01) ? acc >> n :
                 (op == 2'b10) ? $unsigned($signed(acc) >>> n) : rot[WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            dout  <= '0;
            acc   <= '0;
            rem   <= '0;
            op    <= '0;
        end else if (start && !busy) begin
            acc   <= din;
            rem   <= shamt;
            op    <= mode;
            state <= (shamt != '0) ? SHIFT : DONE;
            busy  <= (shamt != '0);
            done  <= (shamt == '0);
            if (shamt == '0) dout <= din;
        end else if (state == SHIFT) begin
            acc <= acc_nx;
            rem <= rem_nx;
            if (rem_nx == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                dout  <= acc_nx;
            end
        end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed checks of shift_unit with STEP=1 and STEP=4 instances.
module tb_shift_unit;
    logic        clk = 1'b0, rst = 1'b1, start1 = 1'b0, start4 = 1'b0;
    logic [1:0]  mode = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] din = '0;
    logic        busy1, done1, busy4, done4;
    logic [31:0] dout1, dout4;
    int          checks = 0, errors = 0;
    int          nd;

    always #5 clk = ~clk;

    shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .shamt(shamt), .din(din),
        .busy(busy1), .done(done1), .dout(dout1)
    );
    shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode), .shamt(shamt), .din(din),
        .busy(busy4), .done(done4), .dout(dout4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Operands are scrambled right after acceptance; inj >= 0 pulses a competing start mid-flight.
    task automatic run_op(input string tag, input bit s4, input bit b2b, input logic [1:0] m,
                          input logic [4:0] sa, input logic [31:0] d, input logic [31:0] exp_dout,
                          input int exp_lat, input int inj);
        int lat = 0, nb = 0;
        if (!b2b) @(negedge clk);
        mode = m; shamt = sa; din = d;
        if (s4) start4 = 1'b1; else start1 = 1'b1;
        for (int k = 0; k < 64 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 0 || k == inj + 1) begin
                start1 = 1'b0; start4 = 1'b0; din = ~d; mode = ~m; shamt = sa ^ 5'h15;
            end
            if (k == inj) begin
                din = 32'hFFFF_FFFF; mode = 2'b01; shamt = 5'd1;
                if (s4) start4 = 1'b1; else start1 = 1'b1;
            end
            if (s4 ? busy4 : busy1) nb++;
            if (s4 ? done4 : done1) lat = k + 1;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, nb, exp_lat - 1);
        check({tag, "_dout"}, s4 ? dout4 : dout1, exp_dout);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_dout1", dout1, 0);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_dout4", dout4, 0);
        rst = 1'b0;
        run_op("sll31", 0, 1, 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 32, -1);
        run_op("sra4",  0, 0, 2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000, 5, -1);
        run_op("srl4",  0, 0, 2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000, 5, -1);
        run_op("ror4",  1, 0, 2'b11, 5'd4,  32'h0000_00F1, 32'h1000_000F, 2, -1);
        run_op("ror5",  1, 0, 2'b11, 5'd5,  32'h0000_00F1, 32'h8800_0007, 3, -1);
        run_op("zero1", 0, 0, 2'b11, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, -1);
        run_op("zero4", 1, 0, 2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, -1);
        run_op("sra31", 1, 0, 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 9, -1);
        run_op("sll7",  1, 0, 2'b00, 5'd7,  32'h0000_00FF, 32'h0000_7F80, 3, -1);
        run_op("inj",   0, 0, 2'b00, 5'd10, 32'h0000_0003, 32'h0000_0C00, 11, 3);
        run_op("b2b_a", 0, 0, 2'b11, 5'd8,  32'h1234_5678, 32'h7812_3456, 9, -1);
        run_op("b2b_b", 0, 1, 2'b00, 5'd3,  32'h0000_0001, 32'h0000_0008, 4, -1);
        @(negedge clk);
        rst = 1'b1; start1 = 1'b1; mode = 2'b00; shamt = 5'd3; din = 32'h1;
        @(negedge clk);
        rst = 1'b0; start1 = 1'b0;
        check("prio_busy", busy1, 0);
        check("prio_done", done1, 0);
        @(negedge clk);
        check("prio_done2", done1, 0);
        run_op("pre_rst", 0, 0, 2'b01, 5'd2, 32'h0000_00F0, 32'h0000_003C, 3, -1);
        @(negedge clk);
        mode = 2'b00; shamt = 5'd20; din = 32'h1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy_pre", busy1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy1, 0);
        check("abort_done", done1, 0);
        check("abort_dout", dout1, 0);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done1 || busy1) nd++;
        end
        check("abort_quiet", nd, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
